// File: rtl/hazard_scoreboard.sv
// D-stage hazard scoreboard: tracks in-flight writers with Tnew countdowns,
// picks the youngest forwarding source per operand and raises stall on Tuse/Tnew or MDU conflicts.
module hazard_scoreboard #(
    parameter int AW      = 5,
    parameter int DEPTH   = 3,
    parameter int TMAX    = 3,
    parameter int TW      = $clog2(TMAX + 1),
    parameter int SW      = $clog2(DEPTH + 1),
    parameter int MDU_LAT = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_valid,
    input  logic [AW-1:0] d_a1,
    input  logic [AW-1:0] d_a2,
    input  logic          d_use1,
    input  logic          d_use2,
    input  logic [TW-1:0] d_tuse1,
    input  logic [TW-1:0] d_tuse2,
    input  logic [AW-1:0] d_a3,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_mdu_start,
    input  logic          d_mdu_use,
    input  logic          flush,
    output logic          stall,
    output logic [SW-1:0] fwd_sel1,
    output logic [SW-1:0] fwd_sel2,
    output logic          fwd_rdy1,
    output logic          fwd_rdy2,
    output logic          mdu_busy
);

    typedef struct packed {
        logic [SW-1:0] sel;
        logic          rdy;
        logic          haz;
    } match_t;

    // Entry k mirrors pipeline stage k (1 = E).
    logic [DEPTH:1]         ent_vld;
    logic [DEPTH:1][AW-1:0] ent_a3;
    logic [DEPTH:1][TW-1:0] ent_tnew;
    logic [7:0]             mdu_cnt;
    logic                   issue;
    match_t                 m1;
    match_t                 m2;

    function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    // The first hit in stage order is the youngest writer and shadows older ones.
    function automatic match_t scan(
        input logic                   use_op,
        input logic [AW-1:0]          a,
        input logic [TW-1:0]          tuse,
        input logic [DEPTH:1]         vld,
        input logic [DEPTH:1][AW-1:0] a3,
        input logic [DEPTH:1][TW-1:0] tnew
    );
        match_t m;
        logic   found;
        m     = '0;
        found = 1'b0;
        if (use_op && (a != '0)) begin
            for (int k = 1; k <= DEPTH; k++) begin
                if (!found && vld[k] && (a3[k] == a)) begin
                    found = 1'b1;
                    m.sel = SW'(k);
                    m.rdy = (tnew[k] == '0);
                    m.haz = (tnew[k] > tuse);
                end
            end
        end
        return m;
    endfunction

    assign m1       = scan(d_use1, d_a1, d_tuse1, ent_vld, ent_a3, ent_tnew);
    assign m2       = scan(d_use2, d_a2, d_tuse2, ent_vld, ent_a3, ent_tnew);
    assign fwd_sel1 = m1.sel;
    assign fwd_rdy1 = m1.rdy;
    assign fwd_sel2 = m2.sel;
    assign fwd_rdy2 = m2.rdy;
    assign mdu_busy = (mdu_cnt != 8'd0);
    assign stall    = d_valid & (m1.haz | m2.haz | (d_mdu_use & mdu_busy));
    assign issue    = d_valid & ~stall & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_vld  <= '0;
            ent_a3   <= '0;
            ent_tnew <= '0;
        end else if (flush) begin
            ent_vld  <= '0;
            ent_a3   <= '0;
            ent_tnew <= '0;
        end else begin
            ent_vld[1]  <= issue && (d_a3 != '0);
            ent_a3[1]   <= issue ? d_a3 : '0;
            ent_tnew[1] <= issue ? d_tnew : '0;
            for (int k = 2; k <= DEPTH; k++) begin
                ent_vld[k]  <= ent_vld[k-1];
                ent_a3[k]   <= ent_a3[k-1];
                ent_tnew[k] <= tnew_dec(ent_tnew[k-1]);
            end
        end
    end

    // MDU occupancy keeps counting through flushes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdu_cnt <= 8'd0;
        end else if (issue && d_mdu_start) begin
            mdu_cnt <= 8'(MDU_LAT);
        end else if (mdu_cnt != 8'd0) begin
            mdu_cnt <= mdu_cnt - 8'd1;
        end
    end

endmodule
